roundtrip_avg_scheduler: RTL

- Shares one external sequential divider among N_CH roundtrip-time channels.
- Each channel presents an accumulated roundtrip-cycle sum and a request count for a finished batch.
- The block grants one channel at a time (round-robin), divides sum by count on the shared divider, and stores the DATA_WIDTH average in that channel's result register.
- Sits between per-accelerator roundtrip accumulators and the monitor CSR readout.

---
 rtl/roundtrip_avg_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/roundtrip_avg_scheduler.sv
// Round-robin arbiter that shares one sequential divider among N_CH roundtrip channels
// and keeps the latest saturated sum/count average for each channel.
module roundtrip_avg_scheduler #(
  parameter int N_CH           = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int SUM_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [N_CH-1:0]              ch_valid_i,
  output logic [N_CH-1:0]              ch_ready_o,
  input  logic [N_CH*SUM_WIDTH-1:0]    ch_sum_i,
  input  logic [N_CH*DATA_WIDTH-1:0]   ch_count_i,
  output logic                         div_start_o,
  output logic [SUM_WIDTH-1:0]         div_dividend_o,
  output logic [DATA_WIDTH-1:0]        div_divisor_o,
  input  logic                         div_done_i,
  input  logic [SUM_WIDTH-1:0]         div_quotient_i,
  output logic [N_CH*DATA_WIDTH-1:0]   result_o,
  output logic [N_CH-1:0]              result_valid_o,
  output logic                         timeout_err_o
);

  localparam int IDX_W = $clog2(N_CH);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [SUM_WIDTH-1:0] AVG_MAX = (SUM_WIDTH'(1) << DATA_WIDTH) - SUM_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT, WRITEBACK} state_t;

  state_t                       state, state_next;
  logic [IDX_W-1:0]             rr, grant, gnt_q, cand;
  logic                         grant_found;
  logic [DATA_WIDTH-1:0]        grant_count, avg;
  logic [SUM_WIDTH-1:0]         sum_q, quot_q;
  logic [DATA_WIDTH-1:0]        cnt_q;
  logic [TMO_W-1:0]             tmo_cnt;
  logic                         tmo_hit;
  logic [N_CH*DATA_WIDTH-1:0]   result_q;
  logic [N_CH-1:0]              result_valid_q;
  logic                         timeout_err_q;
  int                           idx;

  // First valid channel at or after the round-robin pointer, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant       = '0;
    idx         = 0;
    cand        = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(rr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      cand = IDX_W'(idx);
      if (!grant_found && ch_valid_i[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  assign grant_count = ch_count_i[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign avg         = (quot_q > AVG_MAX) ? '1 : quot_q[DATA_WIDTH-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    ch_ready_o  = '0;
    div_start_o = 1'b0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          ch_ready_o[grant] = 1'b1;
          state_next = (grant_count == '0) ? WRITEBACK : START;
        end
      end
      START: begin
        div_start_o = 1'b1;
        state_next  = WAIT;
      end
      WAIT: begin
        if (div_done_i || tmo_hit) state_next = WRITEBACK;
      end
      WRITEBACK: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // A done pulse in the same cycle as the timeout limit still counts as a good result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr             <= '0;
      gnt_q          <= '0;
      sum_q          <= '0;
      cnt_q          <= '0;
      quot_q         <= '0;
      tmo_cnt        <= '0;
      result_q       <= '0;
      result_valid_q <= '0;
      timeout_err_q  <= 1'b0;
    end else begin
      result_valid_q <= '0;
      case (state)
        IDLE: begin
          if (grant_found) begin
            gnt_q  <= grant;
            sum_q  <= ch_sum_i[int'(grant)*SUM_WIDTH +: SUM_WIDTH];
            cnt_q  <= grant_count;
            quot_q <= '0;
          end
        end
        START: tmo_cnt <= '0;
        WAIT: begin
          if (div_done_i) begin
            quot_q <= div_quotient_i;
          end else if (tmo_hit) begin
            quot_q        <= '1;
            timeout_err_q <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WRITEBACK: begin
          result_q[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH] <= avg;
          result_valid_q[gnt_q] <= 1'b1;
          rr <= (gnt_q == IDX_W'(N_CH - 1)) ? '0 : gnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign div_dividend_o = sum_q;
  assign div_divisor_o  = cnt_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign timeout_err_o  = timeout_err_q;

endmodule
